// File: rtl/alu_op_sequencer.sv
// Micro-sequencer for 8-bit ALU ops with register, (HL) or immediate operand: IDLE -> [MEM] -> EXEC.
// Optional immediate-operand path is enabled by defining ALU_SEQ_IMM_EN.
module alu_op_sequencer #(
    parameter int unsigned REG_COUNT       = 8,
    parameter int unsigned STEPS_PER_CYCLE = 4,
    parameter int unsigned HL_INDEX        = 6,
    parameter int unsigned ACC_INDEX       = 7,
    parameter int unsigned ALU_CTRL_W      = 7
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic [REG_COUNT-1:0]  i_Z,
    input  logic [2:0]            i_Op,
    input  logic                  i_Imm,
    input  logic                  i_Mem_Ready,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic                  o_IR_Fetch,
    output logic [REG_COUNT-1:0]  o_Read8,
    output logic [REG_COUNT-1:0]  o_Write8,
    output logic [1:0]            o_Addr_Sel,
    output logic                  o_PC_Inc,
    output logic                  o_Bus_In,
    output logic                  o_Address_Out,
    output logic [1:0]            o_ReadALU8,
    output logic [1:0]            o_WriteALU8,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control
);

    localparam int unsigned StepW = $clog2(STEPS_PER_CYCLE);
    localparam logic [StepW-1:0] AddrStep = StepW'(1);
    localparam logic [StepW-1:0] DataStep = StepW'(2);
    localparam logic [StepW-1:0] LastStep = StepW'(STEPS_PER_CYCLE - 1);
    localparam logic [REG_COUNT-1:0] TempSel = REG_COUNT'(1);

    typedef enum logic [1:0] {StIdle, StMem, StExec} state_e;

    state_e               state_q, state_d;
    logic [StepW-1:0]     step_q, step_d;
    logic [REG_COUNT-1:0] z_q, z_d;
    logic [2:0]           op_q, op_d;
    logic                 imm_q, imm_d;
    logic                 mem_q, mem_d;
    logic                 error_q, error_d;

    logic imm_req;
    logic z_onehot;

`ifdef ALU_SEQ_IMM_EN
    assign imm_req = i_Imm;
`else
    logic unused_imm;
    assign imm_req    = 1'b0;
    assign unused_imm = i_Imm ^ imm_q;
`endif

    assign z_onehot = (i_Z != '0) && ((i_Z & (i_Z - TempSel)) == '0);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            z_q     <= '0;
            op_q    <= '0;
            imm_q   <= 1'b0;
            mem_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            z_q     <= z_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            mem_q   <= mem_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        z_d     = z_q;
        op_d    = op_q;
        imm_d   = imm_q;
        mem_d   = mem_q;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    if (!imm_req && !z_onehot) begin
                        error_d = 1'b1;
                    end else begin
                        z_d     = i_Z;
                        op_d    = i_Op;
                        imm_d   = imm_req;
                        mem_d   = imm_req | i_Z[HL_INDEX];
                        state_d = (imm_req | i_Z[HL_INDEX]) ? StMem : StExec;
                        step_d  = '0;
                    end
                end
            end
            StMem: begin
                // Bus read stalls on the data step until memory signals ready.
                if (step_q == DataStep && !i_Mem_Ready) begin
                    step_d = step_q;
                end else if (step_q == LastStep) begin
                    state_d = StExec;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StExec: begin
                if (step_q == LastStep) begin
                    state_d = StIdle;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        o_Busy        = 1'b0;
        o_Done        = 1'b0;
        o_Error       = error_q;
        o_IR_Fetch    = 1'b0;
        o_Read8       = '0;
        o_Write8      = '0;
        o_Addr_Sel    = 2'b00;
        o_PC_Inc      = 1'b0;
        o_Bus_In      = 1'b0;
        o_Address_Out = 1'b0;
        o_ReadALU8    = 2'b00;
        o_WriteALU8   = 2'b00;
        o_ALU_Control = '0;
        unique case (state_q)
            StMem: begin
                o_Busy = 1'b1;
                if (step_q == AddrStep) begin
                    o_Address_Out = 1'b1;
`ifdef ALU_SEQ_IMM_EN
                    o_Addr_Sel = imm_q ? 2'b10 : 2'b01;
`else
                    o_Addr_Sel = 2'b01;
`endif
                end
                if (step_q == DataStep) begin
                    o_Bus_In    = 1'b1;
                    o_Write8[0] = 1'b1;
`ifdef ALU_SEQ_IMM_EN
                    o_PC_Inc = imm_q & i_Mem_Ready;
`endif
                end
            end
            StExec: begin
                o_Busy     = 1'b1;
                o_IR_Fetch = 1'b1;
                if (step_q == DataStep) begin
                    // Memory/immediate operands were parked in the temp latch (bit 0).
                    o_Read8                   = mem_q ? TempSel : z_q;
                    o_ReadALU8[0]             = ~mem_q & z_q[ACC_INDEX];
                    o_WriteALU8[0]            = (op_q != 3'b111);
                    o_ALU_Control[ALU_CTRL_W-1] = 1'b1;
                    o_ALU_Control[3:1]        = op_q;
                    o_ALU_Control[0]          = 1'b1;
                end
                if (step_q == LastStep) begin
                    o_Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
